mul_add_nat_seq: RTL and testbench

//   Sequential multiply-add for base-2 naturals: m = x*y + c via shift-and-add, one multiplier bit per clock.

---
 rtl/mul_add_nat_seq_if.sv | 18 +
 rtl/mul_add_nat_seq.sv | 106 ++++++++++
 tb/tb_mul_add_nat_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mul_add_nat_seq_if.sv
// Handshake and data bundle between a consumer and the shift-and-add multiply-add unit.
// Consumer drives soc/x/y/c and reads eoc/m; the unit drives eoc/m.
// Parameters must match the N/M of the attached mul_add_nat_seq instance.
`timescale 1ns/1ps
interface mul_add_nat_seq_if #(
  parameter int N = 8,
  parameter int M = 8
);
  logic           soc;
  logic           eoc;
  logic [N-1:0]   x;
  logic [M-1:0]   y;
  logic [N-1:0]   c;
  logic [N+M-1:0] m;

  modport master (output soc, x, y, c, input eoc, m);
  modport slave  (input soc, x, y, c, output eoc, m);
endinterface

// File: rtl/mul_add_nat_seq.sv
// Sequential multiply-add m = x*y + c, one multiplier bit per clock (shift-and-add).
// Latency: start edge + M step edges + 1 end edge; MUL_ADD_NAT_SEQ_EARLY_EN stops after the top set bit of y.
// Backpressure: 4-phase soc/eoc handshake; the result is held in S_END until the consumer drops soc.
`timescale 1ns/1ps
module mul_add_nat_seq #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic              clock,
  input  logic              reset,
  mul_add_nat_seq_if.slave  bus
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_END} state_t;

  state_t         state, state_nxt;
  logic [N+M-1:0] x_q;
  logic [M-1:0]   y_q;
  logic [N+M-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  logic           eoc_q;
  logic [N+M-1:0] m_q;

  logic start, step, finish;
  logic last_step;

  // Decide whether the step taken on this edge is the final one.
  always_comb begin
    last_step = (cnt_q == CW'(1));
`ifdef MUL_ADD_NAT_SEQ_EARLY_EN
    // Once no set bits remain above the current one, further steps only add zero.
    if ((y_q >> 1) == '0) last_step = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.soc) begin
          start     = 1'b1;
          state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        step = 1'b1;
        if (last_step) state_nxt = S_END;
      end
      S_END: begin
        // Waiting for soc low keeps a held soc from relaunching immediately.
        if (!bus.soc) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, shift-and-add accumulation and result publication.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      eoc_q <= 1'b1;
      m_q   <= '0;
    end else begin
      if (start) begin
        x_q   <= {{M{1'b0}}, bus.x};
        y_q   <= bus.y;
        acc_q <= {{M{1'b0}}, bus.c};
        cnt_q <= CW'(M);
        eoc_q <= 1'b0;
      end
      if (step) begin
        // x*y+c < 2^(N+M), so the accumulator never carries out.
        acc_q <= acc_q + (y_q[0] ? x_q : '0);
        x_q   <= x_q << 1;
        y_q   <= y_q >> 1;
        cnt_q <= cnt_q - CW'(1);
      end
      if (finish) begin
        m_q   <= acc_q;
        eoc_q <= 1'b1;
      end
    end
  end

  assign bus.eoc = eoc_q;
  assign bus.m   = m_q;

endmodule

// File: tb/tb_mul_add_nat_seq.sv
`timescale 1ns/1ps
module tb_mul_add_nat_seq;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mul_add_nat_seq_if #(.N(4), .M(4)) a ();
  mul_add_nat_seq_if #(.N(8), .M(8)) b ();

  mul_add_nat_seq #(.N(4), .M(4)) dut4 (.clock(clock), .reset(reset), .bus(a));
  mul_add_nat_seq #(.N(8), .M(8)) dut8 (.clock(clock), .reset(reset), .bus(b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One 4-phase operation on the N=M=4 unit; operands are scrambled after the start edge.
  task automatic op4(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                     input logic [3:0] cv, input int exp_m, input int lat_def,
                     input int lat_early, input int prev_m);
    int n;
    int lat;
`ifdef MUL_ADD_NAT_SEQ_EARLY_EN
    lat = lat_early;
`else
    lat = lat_def;
`endif
    @(negedge clock);
    a.x = xv; a.y = yv; a.c = cv; a.soc = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_busy"}, a.eoc, 0);
    chk({tag, "_mhold"}, a.m, prev_m);
    @(negedge clock);
    a.soc = 1'b0; a.x = ~xv; a.y = ~yv; a.c = ~cv;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!a.eoc && n < 40);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_m"}, a.m, exp_m);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    a.soc = 1'b0; a.x = '0; a.y = '0; a.c = '0;
    b.soc = 1'b0; b.x = '0; b.y = '0; b.c = '0;
    #12;
    chk("rst_eoc4", a.eoc, 1);
    chk("rst_m4",   a.m,   0);
    chk("rst_eoc8", b.eoc, 1);
    chk("rst_m8",   b.m,   0);
    @(negedge clock);
    reset = 1'b0;

    // 3*5+2, then full-scale 15*15+15, then y=0.
    op4("t1", 4'd3,  4'd5,  4'd2,  17,  5, 4, 0);
    op4("t2", 4'd15, 4'd15, 4'd15, 240, 5, 5, 17);
    op4("t3", 4'd7,  4'd0,  4'd9,  9,   5, 2, 240);

    // Full-scale on the default-width unit.
    begin
      int n;
      @(negedge clock);
      b.x = 8'd255; b.y = 8'd255; b.c = 8'd255; b.soc = 1'b1;
      @(posedge clock); #1;
      chk("t2w_busy", b.eoc, 0);
      @(negedge clock);
      b.soc = 1'b0; b.x = '0; b.y = '0; b.c = '0;
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
      end while (!b.eoc && n < 40);
      chk("t2w_lat", n, 9);
      chk("t2w_m", b.m, 65280);
    end

    // soc held high: unit must park in S_END until soc falls.
    @(negedge clock);
    a.x = 4'd6; a.y = 4'd7; a.c = 4'd5; a.soc = 1'b1;
    @(posedge clock); #1;
    chk("t4_busy", a.eoc, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
    end
    chk("t4_held_eoc", a.eoc, 0);
    chk("t4_held_m",   a.m,   9);
    @(negedge clock);
    a.soc = 1'b0;
    @(posedge clock); #1;
    chk("t4_eoc", a.eoc, 1);
    chk("t4_m",   a.m,   47);

    // Asynchronous reset mid-operation.
    @(negedge clock);
    a.x = 4'd1; a.y = 4'd1; a.c = 4'd1; a.soc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    a.soc = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_rst_eoc", a.eoc, 1);
    chk("t5_rst_m",   a.m,   0);
    @(negedge clock);
    reset = 1'b0;
    op4("t5", 4'd2, 4'd3, 4'd1, 7, 5, 3, 0);

    // Back-to-back operations with operands scrambled mid-op.
    op4("t6a", 4'd5, 4'd6,  4'd3, 33,  5, 4, 7);
    op4("t6b", 4'd9, 4'd11, 4'd4, 103, 5, 5, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
